// File: rtl/div_clk_monitor.sv
// Receive-side checker for a divided clock: synchronises it, emits edge ticks,
// measures phase/period lengths and tracks LOCK/FAULT against the expected divide.
module div_clk_monitor #(
    parameter int LOCK_COUNT = 3,
    parameter int TOL        = 0
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        DivClkIn,
    input  logic [9:0]  Div,
    input  logic        ClrFault,
    output logic        RiseTick,
    output logic        FallTick,
    output logic [10:0] Period,
    output logic        PeriodValid,
    output logic        Locked,
    output logic        Fault,
    output logic [1:0]  State
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ACQUIRE = 2'd1,
        LOCKED  = 2'd2,
        FAULT   = 2'd3
    } state_t;

    localparam logic [11:0] TOL_W   = 12'(TOL);
    localparam logic [3:0]  LOCK_W  = 4'(LOCK_COUNT);
    localparam logic [10:0] CNT_MAX = 11'h7FF;

    logic        s1_q, s2_q, s3_q;
    logic        s1_d, s2_d, s3_d;
    logic [10:0] hi_cnt_q, hi_cnt_d;
    logic [10:0] lo_cnt_q, lo_cnt_d;
    logic [9:0]  div_q, div_d;
    logic [3:0]  good_cnt_q, good_cnt_d;
    logic [10:0] period_q, period_d;
    logic        period_valid_q, period_valid_d;
    state_t      state_q, state_d;

    logic        rise, fall;
    logic [10:0] exp_len;
    logic [11:0] lim_hi, lim_lo;
    logic [11:0] period_sum;
    logic        hi_ok, lo_ok, period_good, stuck, bad;

    // Synchroniser and edge detector
    always_comb begin
        s1_d = DivClkIn;
        s2_d = s1_q;
        s3_d = s2_q;
        rise = s2_q & ~s3_q;
        fall = ~s2_q & s3_q;
    end

    // Phase counters count from 1 on their opening edge and hold during the other phase
    always_comb begin
        hi_cnt_d = hi_cnt_q;
        lo_cnt_d = lo_cnt_q;
        if (rise)
            hi_cnt_d = 11'd1;
        else if (s2_q && hi_cnt_q != CNT_MAX)
            hi_cnt_d = hi_cnt_q + 11'd1;
        if (fall)
            lo_cnt_d = 11'd1;
        else if (!s2_q && lo_cnt_q != CNT_MAX)
            lo_cnt_d = lo_cnt_q + 11'd1;
    end

    always_comb begin
        exp_len = {1'b0, div_q} + 11'd1;
        lim_hi  = {1'b0, exp_len} + TOL_W;
        lim_lo  = ({1'b0, exp_len} > TOL_W) ? ({1'b0, exp_len} - TOL_W) : 12'd0;
        hi_ok   = ({1'b0, hi_cnt_q} >= lim_lo) && ({1'b0, hi_cnt_q} <= lim_hi);
        lo_ok   = ({1'b0, lo_cnt_q} >= lim_lo) && ({1'b0, lo_cnt_q} <= lim_hi);
        period_good = hi_ok & lo_ok;
        // Checked on the next count value so the state flips on the same edge the counter overruns
        stuck = (s2_q && ({1'b0, hi_cnt_d} > lim_hi)) ||
                (!s2_q && ({1'b0, lo_cnt_d} > lim_hi));
        bad   = stuck | (rise & ~period_good);
    end

    always_comb begin
        period_sum     = {1'b0, hi_cnt_q} + {1'b0, lo_cnt_q};
        period_d       = period_q;
        period_valid_d = 1'b0;
        if (rise && state_q != IDLE) begin
            period_d       = (period_sum > {1'b0, CNT_MAX}) ? CNT_MAX : period_sum[10:0];
            period_valid_d = 1'b1;
        end
    end

    always_comb begin
        state_d    = state_q;
        good_cnt_d = good_cnt_q;
        div_d      = div_q;
        case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d    = ACQUIRE;
                    div_d      = Div;
                    good_cnt_d = 4'd0;
                end
            end
            ACQUIRE: begin
                if (bad)
                    good_cnt_d = 4'd0;
                else if (rise) begin
                    good_cnt_d = good_cnt_q + 4'd1;
                    if (good_cnt_q + 4'd1 >= LOCK_W)
                        state_d = LOCKED;
                end
            end
            LOCKED: begin
                if (bad)
                    state_d = FAULT;
            end
            FAULT: begin
                if (ClrFault)
                    state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            s1_q           <= 1'b0;
            s2_q           <= 1'b0;
            s3_q           <= 1'b0;
            hi_cnt_q       <= '0;
            lo_cnt_q       <= '0;
            div_q          <= '0;
            good_cnt_q     <= '0;
            period_q       <= '0;
            period_valid_q <= 1'b0;
            state_q        <= IDLE;
        end else begin
            s1_q           <= s1_d;
            s2_q           <= s2_d;
            s3_q           <= s3_d;
            hi_cnt_q       <= hi_cnt_d;
            lo_cnt_q       <= lo_cnt_d;
            div_q          <= div_d;
            good_cnt_q     <= good_cnt_d;
            period_q       <= period_d;
            period_valid_q <= period_valid_d;
            state_q        <= state_d;
        end
    end

    assign RiseTick    = rise;
    assign FallTick    = fall;
    assign Period      = period_q;
    assign PeriodValid = period_valid_q;
    assign Locked      = (state_q == LOCKED);
    assign Fault       = (state_q == FAULT);
    assign State       = state_q;

endmodule

// File: tb/tb_div_clk_monitor.sv
// Directed bench for div_clk_monitor: a TOL=0 and a TOL=1 instance share all inputs.
module tb_div_clk_monitor;

    logic        clk = 1'b0;
    logic        reset;
    logic        div_clk_in;
    logic [9:0]  div;
    logic        clr_fault;

    logic        rise0, fall0, pvalid0, locked0, fault0;
    logic [10:0] period0;
    logic [1:0]  state0;
    logic        rise1, fall1, pvalid1, locked1, fault1;
    logic [10:0] period1;
    logic [1:0]  state1;

    int checks = 0;
    int errors = 0;
    int pv_cnt = 0;
    int last_period = 0;
    int fa0, fa1, lat;

    always #5 clk = ~clk;

    div_clk_monitor #(.LOCK_COUNT(3), .TOL(0)) u_dut0 (
        .clk(clk), .reset(reset), .DivClkIn(div_clk_in), .Div(div), .ClrFault(clr_fault),
        .RiseTick(rise0), .FallTick(fall0), .Period(period0), .PeriodValid(pvalid0),
        .Locked(locked0), .Fault(fault0), .State(state0)
    );

    div_clk_monitor #(.LOCK_COUNT(3), .TOL(1)) u_dut1 (
        .clk(clk), .reset(reset), .DivClkIn(div_clk_in), .Div(div), .ClrFault(clr_fault),
        .RiseTick(rise1), .FallTick(fall1), .Period(period1), .PeriodValid(pvalid1),
        .Locked(locked1), .Fault(fault1), .State(state1)
    );

    task automatic check(input string tag, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // One cycle: wait for the falling edge, then log any Period update from dut0
    task automatic step();
        @(negedge clk);
        if (pvalid0) begin
            pv_cnt++;
            last_period = int'(period0);
        end
    endtask

    task automatic run_periods(input int h, input int l, input int n);
        for (int i = 0; i < n; i++) begin
            div_clk_in = 1'b1;
            repeat (h) step();
            div_clk_in = 1'b0;
            repeat (l) step();
        end
    endtask

    // Drive high for hi_len cycles (then low), recording the first cycle each Fault rises
    task automatic high_watch(input int hi_len, input int n);
        fa0 = -1;
        fa1 = -1;
        div_clk_in = 1'b1;
        for (int k = 1; k <= n; k++) begin
            step();
            if (fault0 && fa0 < 0) fa0 = k;
            if (fault1 && fa1 < 0) fa1 = k;
            if (k == hi_len) div_clk_in = 1'b0;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        div_clk_in = 1'b0;
        repeat (3) step();
        reset = 1'b0;
        repeat (4) step();
        pv_cnt = 0;
        last_period = 0;
    endtask

    initial begin
        reset      = 1'b1;
        div_clk_in = 1'b0;
        div        = 10'd4;
        clr_fault  = 1'b0;

        // Reset held while the input toggles
        for (int i = 0; i < 6; i++) begin
            div_clk_in = ~div_clk_in;
            step();
        end
        check("rst_rise", rise0, 0);
        check("rst_fall", fall0, 0);
        check("rst_period", period0, 0);
        check("rst_pvalid", pvalid0, 0);
        check("rst_locked", locked0, 0);
        check("rst_fault", fault0, 0);
        check("rst_state", state0, 0);
        check("rst_state_tol1", state1, 0);

        // Tick is high in the 3rd cycle after the change (seen on the 2nd falling edge)
        div_clk_in = 1'b0;
        reset = 1'b0;
        repeat (4) step();
        div_clk_in = 1'b1;
        lat = -1;
        for (int k = 1; k <= 6; k++) begin
            step();
            if (rise0 && lat < 0) lat = k;
        end
        check("rise_latency", lat, 2);

        // Div=4, 5/5 periods: lock after the 3rd evaluated period
        do_reset();
        run_periods(5, 5, 3);
        check("acq_state", state0, 1);
        check("acq_pv_cnt", pv_cnt, 2);
        check("acq_period", last_period, 10);
        run_periods(5, 5, 1);
        check("lock_state", state0, 2);
        check("lock_locked", locked0, 1);
        check("lock_locked_tol1", locked1, 1);
        check("lock_pv_cnt", pv_cnt, 3);

        // One 6-cycle high phase: TOL=0 faults as hi_cnt reaches 6, TOL=1 accepts it
        pv_cnt = 0;
        high_watch(6, 11);
        check("stretch_fault_at", fa0, 8);
        check("stretch_tol1_no_fault", fa1, -1);
        run_periods(5, 5, 1);
        check("fault_sticky", state0, 3);
        check("fault_pv_cnt", pv_cnt, 2);
        check("fault_period", last_period, 11);
        check("tol1_still_locked", locked1, 1);
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
        check("clr_to_idle", state0, 0);
        check("clr_ignored_locked", state1, 2);

        // Stuck high after lock, no falling edge
        do_reset();
        run_periods(5, 5, 4);
        check("relock", locked0, 1);
        high_watch(100, 12);
        check("stuck_fault_at", fa0, 8);
        check("stuck_fault_at_tol1", fa1, 9);
        check("stuck_fault_flag", fault1, 1);

        // Div change while locked is ignored until IDLE re-entry
        do_reset();
        run_periods(5, 5, 4);
        div = 10'd9;
        run_periods(5, 5, 2);
        check("div_chg_locked", locked0, 1);
        check("div_chg_period", last_period, 10);
        high_watch(100, 12);
        check("div_chg_fault", state0, 3);
        clr_fault = 1'b1;
        step();
        clr_fault = 1'b0;
        check("div_chg_idle", state0, 0);
        div_clk_in = 1'b0;
        repeat (10) step();
        pv_cnt = 0;
        run_periods(10, 10, 3);
        check("new_div_acq", state0, 1);
        run_periods(10, 10, 1);
        check("new_div_locked", locked0, 1);
        check("new_div_period", last_period, 20);
        check("new_div_pv_cnt", pv_cnt, 3);

        // Div=1023: 1024-cycle phases accepted, period saturates
        div = 10'd1023;
        do_reset();
        run_periods(1024, 1024, 4);
        check("max_locked", locked0, 1);
        check("max_period_sat", last_period, 2047);
        check("max_pv_cnt", pv_cnt, 3);

        // Async reset mid-high-phase clears outputs before the next clock edge
        div_clk_in = 1'b1;
        repeat (10) step();
        check("pre_rst_locked", locked0, 1);
        reset = 1'b1;
        #1;
        check("async_rst_state", state0, 0);
        check("async_rst_locked", locked0, 0);
        check("async_rst_period", period0, 0);
        check("async_rst_state_tol1", state1, 0);
        reset = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
